bus_rr_nxm: RTL and testbench
=============================

BUS_RR_NXM -- requirements
Module: bus_rr_nxm

Interface
REQ-001 Parameter NUM_M, default 4, master count, legal 2..8.
REQ-002 Parameter NUM_S, default 4, slave count, legal 2..8.
REQ-003 Parameter AW, default 8, address width; DW, default 32, data width.
REQ-004 Parameter SEL_BITS, default 3, address MSBs used for slave decode, SEL_BITS < AW, 2^SEL_BITS >= NUM_S.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 M_req  in  NUM_M  per-master bus request.
REQ-008 M_wr  in  NUM_M  per-master write strobe, 1 = write.
REQ-009 M_address  in  NUM_M*AW  master i address at [i*AW +: AW].
REQ-010 M_dout  in  NUM_M*DW  master i write data at [i*DW +: DW].
REQ-011 S_dout  in  NUM_S*DW  slave k read data at [k*DW +: DW].
REQ-012 M_grant  out  NUM_M  one-hot-or-zero grant, registered.
REQ-013 M_din  out  DW  read data returned to masters.
REQ-014 S_sel  out  NUM_S  one-hot-or-zero slave select.
REQ-015 S_address  out  AW; S_wr  out  1; S_din  out  DW  forwarded from granted master.
REQ-016 M_err  out  1  decode-error flag (see REQ-031).

Function
REQ-017 Arbiter SHALL hold state IDLE (no grant) or OWN(i) (M_grant[i]=1); M_grant changes only on rising clk.
REQ-018 OWN(i) with M_req[i]=1 SHALL remain OWN(i) regardless of other requests (lock while requesting).
REQ-019 IDLE, or OWN(i) with M_req[i]=0, SHALL move to OWN(j), j = first requester scanning (last+1) mod NUM_M upward with wrap, where last = most recent owner; no requester -> IDLE.
REQ-020 Handover SHALL occur on the same edge the owner's request is seen low: no idle bubble between owners.
REQ-021 Grant latency: request asserted in cycle n into IDLE -> M_grant set after edge n+1.
REQ-022 With no grant, S_wr, S_address, S_din SHALL be 0 and S_sel all 0.
REQ-023 With OWN(i), S_wr, S_address, S_din SHALL combinationally equal master i fields.
REQ-024 S_sel[k] SHALL be 1 iff granted and S_address[AW-1 -: SEL_BITS] == k and k < NUM_S.
REQ-025 Decode value >= NUM_S SHALL be unmapped: S_sel all 0, S_wr still forwarded.
REQ-026 Read-select register rsel SHALL capture {S_sel, unmapped-and-granted} each edge; M_din SHALL be S_dout of slave selected by rsel (one-cycle read latency).
REQ-027 rsel all zero SHALL give M_din = 0.
REQ-028 Granted master's field changes SHALL propagate to slave side in the same cycle.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, last = NUM_M-1 (master 0 wins first), rsel = 0, M_grant = 0, M_din = 0, M_err = 0.
REQ-030 Reset asserted mid-ownership SHALL drop grant immediately; after release, arbitration restarts from master 0 priority.

Configuration
REQ-031 Macro BUS_RR_DECERR_EN defined: a granted unmapped access SHALL set M_err = 1 and M_din = 32'hDEAD_BEEF (low DW bits) in the following cycle, cleared next cycle unless repeated.
REQ-032 BUS_RR_DECERR_EN undefined: M_err SHALL be constant 0 and unmapped reads return 0.

Verification
REQ-033 Reset, then M_req=4'b0001 -> M_grant=0 first cycle, 4'b0001 after one edge; S_sel follows M_address[0]=8'h20 -> S_sel=4'b0010.
REQ-034 M_req=4'b1111 held, each owner drops req for one cycle after 2 cycles -> grant order 0,1,2,3,0 with no IDLE cycle.
REQ-035 Owner 2 holding, M_req[3] and M_req[0] asserted -> grant stays 4'b0100 until M_req[2]=0, then 4'b1000.
REQ-036 Master 1 read 8'h60 with S_dout slave 3 = 32'h1234_5678 -> M_din = 32'h1234_5678 exactly one cycle after S_sel=4'b1000.
REQ-037 Master 0 address 8'hA0 (decode 5, NUM_S=4) -> S_sel=0; with BUS_RR_DECERR_EN M_err=1, M_din=32'hDEAD_BEEF next cycle; without, M_err=0, M_din=0.
REQ-038 reset pulsed while OWN(3) -> M_grant=0 without clock edge; after release M_req=4'b1001 -> grant 4'b0001.

Source files
------------

// File: rtl/bus_rr_nxm.sv
// bus_rr_nxm: NUM_M-master / NUM_S-slave shared bus with a round-robin,
// lock-while-requesting arbiter and MSB address decode.
// Optional feature macro: BUS_RR_DECERR_EN. When it is defined, a granted
// access to an unmapped slave index raises M_err and returns 32'hDEAD_BEEF
// one cycle later. When it is undefined, M_err is 0 and unmapped reads return 0.
module bus_rr_nxm #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned NUM_S    = 4,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned SEL_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M-1:0]    M_req,
  input  logic [NUM_M-1:0]    M_wr,
  input  logic [NUM_M*AW-1:0] M_address,
  input  logic [NUM_M*DW-1:0] M_dout,
  input  logic [NUM_S*DW-1:0] S_dout,
  output logic [NUM_M-1:0]    M_grant,
  output logic [DW-1:0]       M_din,
  output logic [NUM_S-1:0]    S_sel,
  output logic [AW-1:0]       S_address,
  output logic                S_wr,
  output logic [DW-1:0]       S_din,
  output logic                M_err
);

  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned RW = NUM_S + 1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [IW-1:0]       last, last_nxt;
  logic [IW-1:0]       pick;
  logic                found;
  int unsigned         scan_idx;
  logic [NUM_M-1:0]    grant_nxt;
  logic                granted;
  logic [SEL_BITS-1:0] dec;
  logic                unmapped;
  logic [RW-1:0]       rsel;
  logic [DW-1:0]       rdata;

  assign granted = (state == ST_OWN);

  // Round-robin scan: first requester after the most recent owner, with wrap
  always_comb begin
    found    = 1'b0;
    pick     = last;
    scan_idx = 0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      scan_idx = (32'(last) + k) % NUM_M;
      if (!found && M_req[IW'(scan_idx)]) begin
        found = 1'b1;
        pick  = IW'(scan_idx);
      end
    end
  end

  // Arbiter next state: hold while the owner requests, hand over on release
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_OWN;
          owner_nxt = pick;
          last_nxt  = pick;
        end
      end
      ST_OWN: begin
        if (!M_req[owner]) begin
          if (found) begin
            owner_nxt = pick;
            last_nxt  = pick;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt == ST_OWN) grant_nxt[owner_nxt] = 1'b1;
  end

  // Arbiter state, registered grant and read-select capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      last    <= IW'(NUM_M - 1);
      M_grant <= '0;
      rsel    <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      M_grant <= grant_nxt;
      rsel    <= {S_sel, unmapped};
    end
  end

  // Forward the granted master's request fields to the slave side
  always_comb begin
    S_wr      = 1'b0;
    S_address = '0;
    S_din     = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (granted && owner == IW'(i)) begin
        S_wr      = M_wr[i];
        S_address = M_address[i*AW +: AW];
        S_din     = M_dout[i*DW +: DW];
      end
    end
  end

  assign dec      = S_address[AW-1 -: SEL_BITS];
  assign unmapped = granted && (32'(dec) >= NUM_S);

  // Slave select from the address MSBs; indices >= NUM_S select nothing
  always_comb begin
    S_sel = '0;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      if (granted && dec == SEL_BITS'(k)) S_sel[k] = 1'b1;
    end
  end

  // Read return mux, steered by the select captured on the previous edge
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      if (rsel[k+1]) rdata = S_dout[k*DW +: DW];
    end
`ifdef BUS_RR_DECERR_EN
    if (rsel[0]) rdata = DW'(32'hDEAD_BEEF);
`else
    if (rsel[0]) rdata = '0;
`endif
  end

  assign M_din = rdata;

`ifdef BUS_RR_DECERR_EN
  assign M_err = rsel[0];
`else
  assign M_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_nxm.sv
// tb_bus_rr_nxm: directed scenarios plus a randomized run against a
// behavioural model of the round-robin bus.
`timescale 1ns/1ps
module tb_bus_rr_nxm;

  localparam int NUM_M = 4, NUM_S = 4, AW = 8, DW = 32, SEL_BITS = 3;
`ifdef BUS_RR_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NUM_M-1:0] M_req = '0, M_wr = '0;
  logic [AW-1:0] addr_a [NUM_M];
  logic [DW-1:0] mdout_a [NUM_M];
  logic [DW-1:0] sdout_a [NUM_S];
  logic [NUM_M*AW-1:0] M_address;
  logic [NUM_M*DW-1:0] M_dout;
  logic [NUM_S*DW-1:0] S_dout;
  logic [NUM_M-1:0] M_grant;
  logic [DW-1:0] M_din, S_din;
  logic [NUM_S-1:0] S_sel;
  logic [AW-1:0] S_address;
  logic S_wr, M_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      M_address[i*AW +: AW] = addr_a[i];
      M_dout[i*DW +: DW]    = mdout_a[i];
    end
    for (int k = 0; k < NUM_S; k++) S_dout[k*DW +: DW] = sdout_a[k];
  end

  bus_rr_nxm #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SEL_BITS(SEL_BITS)) dut (
    .clk(clk), .reset(reset), .M_req(M_req), .M_wr(M_wr), .M_address(M_address),
    .M_dout(M_dout), .S_dout(S_dout), .M_grant(M_grant), .M_din(M_din), .S_sel(S_sel),
    .S_address(S_address), .S_wr(S_wr), .S_din(S_din), .M_err(M_err)
  );

  // Behavioural model: owner (-1 = idle), last owner, slave latched for read return
  int m_owner, m_last, m_rslave;
  bit m_runm;
  logic [NUM_M-1:0] exp_grant;
  logic [NUM_S-1:0] exp_sel;
  logic exp_wr, exp_err;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_sdin, exp_mdin;

  task automatic model_reset();
    m_owner = -1; m_last = NUM_M - 1; m_rslave = -1; m_runm = 0;
  endtask

  // Applies one clock edge to the model using the inputs present before it
  task automatic model_edge();
    int slave, nxt;
    m_rslave = -1; m_runm = 0;
    if (m_owner >= 0) begin
      slave = int'(addr_a[m_owner]) / (1 << (AW - SEL_BITS));
      if (slave < NUM_S) m_rslave = slave; else m_runm = 1;
    end
    if (!(m_owner >= 0 && M_req[m_owner])) begin
      nxt = -1;
      for (int k = 1; k <= NUM_M; k++)
        if (nxt < 0 && M_req[(m_last + k) % NUM_M]) nxt = (m_last + k) % NUM_M;
      m_owner = nxt;
      if (nxt >= 0) m_last = nxt;
    end
  endtask

  task automatic model_outputs();
    int slave;
    exp_grant = '0; exp_sel = '0; exp_wr = 0; exp_addr = '0; exp_sdin = '0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_wr   = M_wr[m_owner];
      exp_addr = addr_a[m_owner];
      exp_sdin = mdout_a[m_owner];
      slave = int'(addr_a[m_owner]) / (1 << (AW - SEL_BITS));
      if (slave < NUM_S) exp_sel[slave] = 1'b1;
    end
    if (m_rslave >= 0) exp_mdin = sdout_a[m_rslave];
    else if (m_runm && DECERR) exp_mdin = 32'hDEAD_BEEF;
    else exp_mdin = '0;
    exp_err = DECERR && m_runm;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    M_req = '0; M_wr = '0;
    for (int i = 0; i < NUM_M; i++) begin addr_a[i] = '0; mdout_a[i] = '0; end
    for (int k = 0; k < NUM_S; k++) sdout_a[k] = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    M_req = '1;
    addr_a[0] = 8'h20;
    #1 reset = 1'b1;
    #1;
    checks++; if (M_grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want %b", M_grant, 4'b0000); end
    checks++; if (M_din !== 32'h0) begin failures++; $display("FAIL reset_mdin: got %h want %h", M_din, 32'h0); end
    checks++; if (M_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", M_err); end
    checks++; if (S_sel !== 4'b0000 || S_wr !== 1'b0 || S_address !== 8'h00) begin
      failures++; $display("FAIL reset_slave_side: sel=%b wr=%b addr=%h want 0", S_sel, S_wr, S_address); end
    @(posedge clk); #1;
    checks++; if (M_grant !== 4'b0000) begin failures++; $display("FAIL reset_held_grant: got %b want 0000", M_grant); end
    reset = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_first_grant();
    reset_dut();
    M_req = 4'b0001; addr_a[0] = 8'h20; mdout_a[0] = 32'hCAFE_0001; M_wr = 4'b0001;
    #1;
    checks++; if (M_grant !== 4'b0000) begin failures++; $display("FAIL first_grant_latency: got %b want 0000", M_grant); end
    checks++; if (S_sel !== 4'b0000 || S_wr !== 1'b0 || S_din !== 32'h0) begin
      failures++; $display("FAIL idle_slave_side: sel=%b wr=%b din=%h want 0", S_sel, S_wr, S_din); end
    step();
    checks++; if (M_grant !== 4'b0001) begin failures++; $display("FAIL first_grant: got %b want 0001", M_grant); end
    checks++; if (S_sel !== 4'b0010) begin failures++; $display("FAIL first_sel: got %b want 0010", S_sel); end
    checks++; if (S_address !== 8'h20 || S_wr !== 1'b1 || S_din !== 32'hCAFE_0001) begin
      failures++; $display("FAIL first_forward: addr=%h wr=%b din=%h want 20 1 cafe0001", S_address, S_wr, S_din); end
    addr_a[0] = 8'h40; mdout_a[0] = 32'h0BAD_F00D;
    #1;
    checks++; if (S_address !== 8'h40 || S_sel !== 4'b0100 || S_din !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL same_cycle_forward: addr=%h sel=%b din=%h want 40 0100 0badf00d", S_address, S_sel, S_din); end
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NUM_M-1:0] want;
    reset_dut();
    M_req = 4'b1111;
    step();
    want = 4'(1) << order[0];
    checks++; if (M_grant !== want) begin failures++; $display("FAIL rot_start: got %b want %b", M_grant, want); end
    for (int n = 0; n < 4; n++) begin
      step();
      want = 4'(1) << order[n];
      checks++; if (M_grant !== want) begin failures++; $display("FAIL rot_hold%0d: got %b want %b", n, M_grant, want); end
      M_req[order[n]] = 1'b0;
      step();
      want = 4'(1) << order[n+1];
      checks++; if (M_grant !== want) begin failures++; $display("FAIL rot_handover%0d: got %b want %b", n, M_grant, want); end
      M_req[order[n]] = 1'b1;
    end
  endtask

  task automatic test_lock();
    reset_dut();
    M_req = 4'b0100;
    step();
    checks++; if (M_grant !== 4'b0100) begin failures++; $display("FAIL lock_own2: got %b want 0100", M_grant); end
    M_req = 4'b1101;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (M_grant !== 4'b0100) begin failures++; $display("FAIL lock_hold%0d: got %b want 0100", n, M_grant); end
    end
    M_req = 4'b1001;
    step();
    checks++; if (M_grant !== 4'b1000) begin failures++; $display("FAIL lock_release: got %b want 1000", M_grant); end
  endtask

  task automatic test_read_latency();
    reset_dut();
    sdout_a[0] = 32'h1111_0000; sdout_a[1] = 32'h2222_0000; sdout_a[2] = 32'h3333_0000;
    sdout_a[3] = 32'h1234_5678;
    M_req = 4'b0010; addr_a[1] = 8'h60;
    step();
    checks++; if (S_sel !== 4'b1000) begin failures++; $display("FAIL read_sel: got %b want 1000", S_sel); end
    checks++; if (M_din !== 32'h0) begin failures++; $display("FAIL read_early: got %h want 00000000", M_din); end
    step();
    checks++; if (M_din !== 32'h1234_5678) begin failures++; $display("FAIL read_data: got %h want 12345678", M_din); end
  endtask

  task automatic test_unmapped();
    logic [DW-1:0] want_din;
    reset_dut();
    sdout_a[0] = 32'hAAAA_AAAA; sdout_a[1] = 32'hBBBB_BBBB;
    M_req = 4'b0001; addr_a[0] = 8'hA0; M_wr = 4'b0001;
    step();
    checks++; if (S_sel !== 4'b0000 || S_wr !== 1'b1 || M_grant !== 4'b0001) begin
      failures++; $display("FAIL unmapped_fwd: sel=%b wr=%b grant=%b want 0000 1 0001", S_sel, S_wr, M_grant); end
    checks++; if (M_err !== 1'b0) begin failures++; $display("FAIL unmapped_err_early: got %b want 0", M_err); end
    M_req = 4'b0000;
    step();
    want_din = DECERR ? 32'hDEAD_BEEF : 32'h0;
    checks++; if (M_err !== DECERR) begin failures++; $display("FAIL unmapped_err: got %b want %b", M_err, DECERR); end
    checks++; if (M_din !== want_din) begin failures++; $display("FAIL unmapped_din: got %h want %h", M_din, want_din); end
    step();
    checks++; if (M_err !== 1'b0 || M_din !== 32'h0) begin
      failures++; $display("FAIL unmapped_clear: err=%b din=%h want 0 00000000", M_err, M_din); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    M_req = 4'b1000;
    step();
    checks++; if (M_grant !== 4'b1000) begin failures++; $display("FAIL mid_own3: got %b want 1000", M_grant); end
    #2 reset = 1'b1;
    #1;
    checks++; if (M_grant !== 4'b0000 || S_sel !== 4'b0000) begin
      failures++; $display("FAIL mid_async_drop: grant=%b sel=%b want 0000 0000", M_grant, S_sel); end
    reset = 1'b0;
    model_reset();
    M_req = 4'b1001;
    step();
    checks++; if (M_grant !== 4'b0001) begin failures++; $display("FAIL mid_restart: got %b want 0001", M_grant); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_M; i++) begin
        M_req[i]   = (i == m_owner) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        M_wr[i]    = 1'($urandom_range(0, 1));
        addr_a[i]  = 8'($urandom_range(0, 255));
        mdout_a[i] = $urandom;
      end
      for (int k = 0; k < NUM_S; k++) sdout_a[k] = $urandom;
      #1;
      model_outputs();
      checks++; if (M_grant !== exp_grant) begin failures++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, M_grant, exp_grant); end
      checks++; if (S_sel !== exp_sel) begin failures++; $display("FAIL rnd_sel c=%0d: got %b want %b", c, S_sel, exp_sel); end
      checks++; if (S_wr !== exp_wr || S_address !== exp_addr || S_din !== exp_sdin) begin
        failures++; $display("FAIL rnd_fwd c=%0d: wr=%b addr=%h din=%h want %b %h %h", c, S_wr, S_address, S_din, exp_wr, exp_addr, exp_sdin); end
      checks++; if (M_din !== exp_mdin) begin failures++; $display("FAIL rnd_mdin c=%0d: got %h want %h", c, M_din, exp_mdin); end
      checks++; if (M_err !== exp_err) begin failures++; $display("FAIL rnd_err c=%0d: got %b want %b", c, M_err, exp_err); end
      step();
    end
  endtask

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_first_grant();
    test_rotation();
    test_lock();
    test_read_latency();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
